// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl
// Description : Time-multiplexed scan controller for a common-anode 7-segment
//               display, sharing one external hex decoder across all digits.
//               Optional build macro: SSD_LEADING_ZERO_BLANK_EN
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic                          load,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [3:0]                    nib_out,
    input  logic [6:0]                    seg_in,
    output logic [6:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [0:0]            c_st_gap   = 1'b0;
    localparam logic [0:0]            c_st_on    = 1'b1;
    localparam logic [CNT_W-1:0]      c_gap_last = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      c_on_last  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_seg_off  = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] c_an_off   = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] c_an_one   = NUM_DIGITS'(1);

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic                    w_phase_end;
    logic                    w_enter_gap;
    logic                    w_wrap;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic                    w_blank;
    logic [6:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_gap;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_phase_end = 1'b0;
        case (r_state)
            c_st_gap: begin
                if (r_cnt == c_gap_last) begin
                    w_phase_end = 1'b1;
                    w_state_nxt = c_st_on;
                end
            end
            c_st_on: begin
                if (r_cnt == c_on_last) begin
                    w_phase_end = 1'b1;
                    w_state_nxt = c_st_gap;
                end
            end
            default: begin
                w_state_nxt = c_st_gap;
            end
        endcase
    end

    assign w_enter_gap = (r_state == c_st_on) && w_phase_end;
    assign w_wrap      = w_enter_gap && (r_idx == c_idx_last);

    // Leading-zero suppression looks at the displayed (active) value only
`ifdef SSD_LEADING_ZERO_BLANK_EN
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        if (gi == 0) begin : g_units
            assign w_lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign w_lz_blank[gi] = (r_active[4*NUM_DIGITS-1:4*gi] == '0);
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    assign w_blank = blank_mask[r_idx] | w_lz_blank[r_idx];

    // ------------------------------------------------------------------
    // FSM: output logic
    // Decoded from the next state so the pins line up with the phase:
    // r_idx is already the new digit on the GAP->ON edge, and seg_in has
    // been settling on that digit for the whole gap.
    // ------------------------------------------------------------------
    always_comb begin
        w_seg_nxt = c_seg_off;
        w_an_nxt  = c_an_off;
        if ((w_state_nxt == c_st_on) && !w_blank) begin
            w_seg_nxt = seg_in;
            w_an_nxt  = ~(c_an_one << r_idx);
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_seg        <= c_seg_off;
            r_an         <= c_an_off;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_phase_end ? '0 : r_cnt + CNT_W'(1);
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
            r_frame_done <= w_wrap;
            if (w_enter_gap) begin
                r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
            end
            // active samples the old shadow, so a coincident load waits a frame
            if (w_wrap) begin
                r_active <= r_shadow;
            end
            if (load) begin
                r_shadow <= digits_in;
            end
        end
    end

    assign nib_out    = r_active[{r_idx, 2'b00} +: 4];
    assign seg_out    = r_seg;
    assign an_out     = r_an;
    assign digit_idx  = r_idx;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_ctrl
// Description : Randomized bench for ssd_scan_ctrl against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_ctrl;

    localparam int N = 4;
    localparam int R = 4;
    localparam int D = 1;
    localparam int L = R + D;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  blank_mask;
    logic [3:0]  nib_out;
    logic [6:0]  seg_in;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Model: position on the scan timeline since reset plus the two value registers
    int          p;
    logic [15:0] m_shadow;
    logic [15:0] m_active;
    logic [3:0]  m_blank;

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
        endcase
    endfunction

    assign seg_in = hex7(nib_out);

    ssd_scan_ctrl #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(R),
        .DEAD_CYCLES(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .load      (load),
        .blank_mask(blank_mask),
        .nib_out   (nib_out),
        .seg_in    (seg_in),
        .seg_out   (seg_out),
        .an_out    (an_out),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic ld, input logic [15:0] din,
                              input logic [3:0] bm);
        if (r) begin
            p        = 0;
            m_shadow = '0;
            m_active = '0;
        end else begin
            p = p + 1;
            if ((p % L == 0) && ((p / L) % N == 0)) m_active = m_shadow;
            if (ld) m_shadow = din;
        end
        m_blank = bm;
    endtask

    task automatic check_outputs();
        int          s;
        int          o;
        int          idx;
        logic        dark;
        logic [3:0]  nib;
        logic [3:0]  an_exp;
        logic [6:0]  seg_exp;
        s    = p / L;
        o    = p % L;
        idx  = s % N;
        nib  = m_active[4*idx +: 4];
        dark = (o < D) || m_blank[idx];
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (idx > 0 && (m_active >> (4*idx)) == 16'h0) dark = 1'b1;
`endif
        an_exp  = dark ? 4'hF : ~(4'b0001 << idx);
        seg_exp = dark ? 7'h7F : hex7(nib);
        check("digit_idx",  32'(digit_idx),  32'(idx));
        check("frame_done", 32'(frame_done), 32'((o == 0) && (s > 0) && (idx == 0)));
        check("nib_out",    32'(nib_out),    32'(nib));
        check("an_out",     32'(an_out),     32'(an_exp));
        check("seg_out",    32'(seg_out),    32'(seg_exp));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, load, digits_in, blank_mask);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        digits_in = v;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        digits_in  = '0;
        blank_mask = '0;
        p          = 0;
        m_shadow   = '0;
        m_active   = '0;
        m_blank    = '0;
        run(3);
        rst = 1'b0;

        do_load(16'h1234);
        run(60);
        blank_mask = 4'b1000;
        run(25);
        blank_mask = 4'b0000;
        run(7);
        do_load(16'hABCD);
        run(40);
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        do_load(16'h0070);
        run(45);

        for (int i = 0; i < 2500; i++) begin
            logic [15:0] v;
            logic        wrap_next;
            rst       = ($urandom_range(0, 299) == 0);
            wrap_next = (((p + 1) % L) == 0) && ((((p + 1) / L) % N) == 0);
            load      = ($urandom_range(0, 7) == 0) || (wrap_next && $urandom_range(0, 1) == 1);
            v         = 16'($urandom);
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'h0;
            digits_in = v;
            if ($urandom_range(0, 49) == 0)
                blank_mask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
